// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  dmem_responder : RV32I data-memory responder (RAM, MMIO, fault capture, scrub)
//  Revision 1.0
// ============================================================================
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DAddr,
  input  logic [31:0] WData,
  input  logic [1:0]  DWidth,
  input  logic        RdMem,
  input  logic        WrMem,
  output logic [31:0] RData,
  output logic        Busy,
  output logic        Fault,
  output logic [31:0] FaultAddr,
  output logic        ConsoleValid,
  output logic [7:0]  ConsoleData,
  output logic        Halt,
  output logic [31:0] HaltCode
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_SCRUB  = 2'd0,
    S_READY  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     cycle_q;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic            fault_q;
  logic [31:0]     fault_addr_q;
  logic            con_valid_q;
  logic [7:0]      con_data_q;
  logic            halt_q;
  logic [31:0]     halt_code_q;

  logic            is_ram, is_mmio, sel_con, sel_halt, sel_cnt;
  logic            misalign, bad, ld_ok, st_ok, fault_now;
  logic [AW-1:0]   widx;
  logic [31:0]     rd_word, shifted, wdata;
  logic [3:0]      be;

  assign widx = DAddr[AW+1:2];

  // Address decode and legality
  always_comb begin
    is_ram   = (DAddr[31:AW+2] == '0);
    is_mmio  = (DAddr[31:16] == MMIO_BASE[31:16]);
    sel_con  = is_mmio && (DAddr[15:0] == 16'h0000);
    sel_halt = is_mmio && (DAddr[15:0] == 16'h0004);
    sel_cnt  = is_mmio && (DAddr[15:0] == 16'h0008);
    misalign = is_ram && (((DWidth == 2'b01) && DAddr[0]) ||
                          ((DWidth == 2'b10) && (DAddr[1:0] != 2'b00)));
    bad      = !(is_ram || sel_con || sel_halt || sel_cnt) || misalign ||
               (DWidth == 2'b11);
    ld_ok    = (state_q != S_SCRUB) && RdMem && !WrMem && !bad;
    st_ok    = !reset && (state_q == S_READY) && WrMem && !RdMem && !bad;
    // Stores are silently dropped once halted, so only loads can fault there
    fault_now = ((state_q == S_READY) && (RdMem || WrMem) && (bad || (RdMem && WrMem))) ||
                ((state_q == S_HALTED) && RdMem && !WrMem && bad);
  end

  // Load path; a legal word access is aligned so the shift is zero
  always_comb begin
    rd_word = mem_q[widx];
    shifted = rd_word >> {DAddr[1:0], 3'b000};
    RData   = 32'h0;
    if (ld_ok) begin
      if (is_ram) begin
        case (DWidth)
          2'b00:   RData = {24'h0, shifted[7:0]};
          2'b01:   RData = {16'h0, shifted[15:0]};
          default: RData = shifted;
        endcase
      end else if (sel_cnt) begin
        RData = cycle_q;
      end
    end
  end

  // Store lane steering
  always_comb begin
    case (DWidth)
      2'b00: begin
        be    = 4'b0001 << DAddr[1:0];
        wdata = {4{WData[7:0]}};
      end
      2'b01: begin
        be    = DAddr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WData[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WData;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == S_SCRUB) begin
      mem_q[idx_q] <= 32'h0;
    end else if (st_ok && is_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_SCRUB: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH_WORDS - 1)) state_d = S_READY;
      end
      S_READY: begin
        if (st_ok && sel_halt) state_d = S_HALTED;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_SCRUB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SCRUB;
      idx_q        <= '0;
      cycle_q      <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      con_valid_q  <= 1'b0;
      con_data_q   <= 8'h0;
      halt_q       <= 1'b0;
      halt_code_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cycle_q     <= cycle_q + 32'd1;
      con_valid_q <= st_ok && sel_con;
      if (st_ok && sel_con) con_data_q <= WData[7:0];
      if (st_ok && sel_halt) begin
        halt_q      <= 1'b1;
        halt_code_q <= WData;
      end
      if (fault_now) begin
        fault_q <= 1'b1;
        if (!fault_q) fault_addr_q <= DAddr;
      end
    end
  end

  assign Busy         = (state_q == S_SCRUB);
  assign Fault        = fault_q;
  assign FaultAddr    = fault_addr_q;
  assign ConsoleValid = con_valid_q;
  assign ConsoleData  = con_data_q;
  assign Halt         = halt_q;
  assign HaltCode     = halt_code_q;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle RV32I core. Sits on the core's load/store port: DAddr, WData, DWidth, RdMem, WrMem and RData.
- Services byte, half and word loads and stores to an on-chip RAM. Decodes a small MMIO window for a console register, a halt register and a cycle counter.
- Detects and records illegal accesses.
- Zeroes the RAM after reset with a scrub state machine.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two).
- MMIO_BASE, 32'hFFFF_0000, base address of the MMIO window (64 KiB aligned).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- DAddr  input  32  byte address from the core.
- WData  input  32  store data; the meaningful bits are right-aligned (byte in [7:0], half in [15:0]).
- DWidth  input  2  access width: 00 byte, 01 half, 10 word, 11 illegal.
- RdMem  input  1  load request this cycle.
- WrMem  input  1  store request this cycle.
- RData  output  32  load data, right-aligned, combinational. The core does the sign/zero extension.
- Busy  output  1  high while the post-reset scrub runs.
- Fault  output  1  sticky illegal-access flag.
- FaultAddr  output  32  DAddr of the first faulting access.
- ConsoleValid  output  1  one-cycle pulse per console store.
- ConsoleData  output  8  byte written to the console.
- Halt  output  1  sticky; set by a store to the halt register.
- HaltCode  output  32  WData captured by the halt store.

Behaviour:
- Reset: state SCRUB, scrub index 0, cycle counter 0.
  - Busy=1, Fault=0, FaultAddr=0, ConsoleValid=0, ConsoleData=0, Halt=0, HaltCode=0.
- SCRUB state:
  - Each cycle, write 0 to RAM[index] and increment the index.
  - After index DEPTH_WORDS-1 is written, move to READY; Busy drops in the cycle after the last scrub write.
  - Core requests are ignored during SCRUB: RData=0, no writes, no fault.
  - Total scrub duration is exactly DEPTH_WORDS cycles.
- READY state:
  - Serves requests.
  - A store to the halt register sets Halt, captures HaltCode=WData and moves to HALTED.
- HALTED state:
  - Loads are still served.
  - All stores are ignored and raise no fault.
  - Exits only via reset.
- Reset asserted in any state, including mid-scrub, restarts from SCRUB with index 0.
- Address decode:
  - RAM: DAddr < DEPTH_WORDS*4. Word index is DAddr[log2(DEPTH_WORDS)+1:2]; the byte lane is DAddr[1:0].
  - MMIO_BASE+0x0 console: write-only; reads return 0.
  - MMIO_BASE+0x4 halt: write-only; reads return 0.
  - MMIO_BASE+0x8 cycle counter: read-only; stores are ignored.
  - Any other address with RdMem or WrMem set is a fault.
- Loads: RData is combinational from the current inputs.
  - Byte: RData[7:0] is the addressed byte; RData[31:8]=0.
  - Half: RData[15:0] is the addressed half; RData[31:16]=0.
  - Word: the full word.
  - RData=0 when RdMem=0, on a fault, or in SCRUB.
- Stores: RAM updated at the rising edge using byte enables.
  - Byte: WData[7:0] goes to lane DAddr[1:0].
  - Half: WData[15:0] goes to lanes {DAddr[1],0} and {DAddr[1],1}.
  - Word: all four lanes.
  - Other lanes are unchanged.
- Read during write to the same address in the same cycle: RData returns the pre-edge (old) contents.
- Faults. Each of the following blocks the access (no write, RData=0):
  - Half access with DAddr[0]=1.
  - Word access with DAddr[1:0]!=0.
  - DWidth=11.
  - Unmapped address.
  - RdMem and WrMem both high.
- Fault recording:
  - On the rising edge after a fault, Fault is set.
  - FaultAddr is captured only if Fault was 0, so the first fault wins.
  - Cleared only by reset.
- Console:
  - A store of any width to MMIO_BASE+0 loads ConsoleData=WData[7:0].
  - ConsoleValid is high for exactly the following cycle.
  - Back-to-back stores give back-to-back pulses.
- Cycle counter:
  - Increments every cycle after reset, including SCRUB and HALTED.
  - 32-bit, wraps from 0xFFFF_FFFF to 0.
  - A read returns the pre-edge value.
- MMIO accesses ignore DWidth for alignment purposes, but DAddr[1:0] must be 0; otherwise they fault.

Test Plan:
- Scrub: hold reset 1 cycle, DEPTH_WORDS=16.
  - Busy stays 1 for exactly 16 cycles, then 0.
  - A load of 0x0 during scrub returns 0; afterwards every word reads 0.
  - Reassert reset at cycle 8: Busy is held a further 16 cycles.
- Byte/half lanes:
  - Word store 0x11223344 at 0x10, byte store 0xAA at 0x13, half store 0xBEEF at 0x10.
  - Word load at 0x10 returns 0xAA22BEEF.
  - Byte load at 0x11 returns 0x000000BE.
  - Half load at 0x12 returns 0x0000AA22.
- Faults:
  - Word load at 0x6 → RData=0, Fault=1 next cycle, FaultAddr=0x6.
  - Then a half store at 0x21 → no write; FaultAddr stays 0x6.
  - DWidth=11 and RdMem+WrMem together are also blocked.
- Console: stores of 0x41 then 0x42 to MMIO_BASE on consecutive cycles → ConsoleValid high 2 cycles, ConsoleData 0x41 then 0x42.
- Halt:
  - Store 0x0000_0007 to MMIO_BASE+4 → Halt=1, HaltCode=7.
  - A subsequent word store 0xFFFFFFFF to 0x0 is ignored (reads 0); loads still work; Fault stays 0.
- Counter: read MMIO_BASE+8 at two points N cycles apart → the difference is N; a forced near-wrap value wraps to 0.
